sram_fifo_ctrl: RTL
===================

// Module: sram_fifo_ctrl
// PURPOSE
//   Ready/valid FIFO whose storage is an external single_port_sram (one op per cycle, 1-cycle read latency).
//   Arbitrates SRAM port between writes and prefetch reads; sram_ren & sram_wen are never both high.
//   A 2-entry output buffer absorbs read latency so out_valid/out_data stay stable under back-pressure.
//   Sits directly upstream of single_port_sram; feeds downstream stream consumers.
// PARAMETERS
//   WIDTH  32  data word width; must equal the SRAM WIDTH
//   DEPTH  32  SRAM depth in words; power of two, >= 2; must equal the SRAM DEPTH
// PORTS
//   clk        in   1                    clock
//   rst        in   1                    reset, synchronous, active-high
//   in_valid   in   1                    producer has a word
//   in_ready   out  1                    word accepted this cycle when in_valid & in_ready
//   in_data    in   WIDTH                producer word
//   out_valid  out  1                    out_data holds oldest word
//   out_ready  in   1                    consumer takes word when out_valid & out_ready
//   out_data   out  WIDTH                oldest word (registered)
//   count      out  $clog2(DEPTH+3)      total occupancy = mem_count + inflight + ob_count
//   full       out  1                    mem_count == DEPTH
//   empty      out  1                    count == 0
//   sram_addr  out  $clog2(DEPTH)        SRAM address
//   sram_ren   out  1                    SRAM read enable
//   sram_wen   out  1                    SRAM write enable
//   sram_d     out  WIDTH                SRAM write data (= in_data)
//   sram_q     in   WIDTH                SRAM read data, valid only the cycle after sram_ren
// BEHAVIOUR
//   State: wr_ptr, rd_ptr (wrap DEPTH-1 -> 0), mem_count (0..DEPTH), inflight (1b),
//     ob_count (0..2) with 2-entry buffer ob[0..1], prio_wr (1b).
//   Reset: pointers, mem_count, inflight, ob_count, prio_wr = 0; out_valid=0, count=0, empty=1, full=0.
//     While rst high: in_ready, sram_ren, sram_wen forced 0. Reset mid-operation discards all contents.
//   Requests (comb): rd_req = mem_count>0 & (ob_count + inflight) < 2; wr_ok = mem_count < DEPTH.
//   in_ready = wr_ok & !(rd_req & !prio_wr)   (no comb path from in_valid to in_ready).
//   wr_gnt = in_valid & in_ready; rd_gnt = rd_req & !wr_gnt.
//   sram_wen = wr_gnt, addr = wr_ptr; sram_ren = rd_gnt, addr = rd_ptr; else sram_addr = rd_ptr.
//   Contention (rd_req & in_valid & wr_ok): winner per prio_wr; prio_wr toggles only on contention cycles.
//   Clock edge: wr_gnt -> wr_ptr++; rd_gnt -> rd_ptr++; mem_count += wr_gnt - rd_gnt; inflight <= rd_gnt.
//   inflight high: capture sram_q into ob tail this cycle; same-cycle pop of ob head permitted.
//   out_valid = ob_count > 0; out_data = ob head; pop when out_valid & out_ready.
//   Latency: word pushed at cycle t into empty FIFO -> sram_ren t+1 -> out_valid at t+3. No bypass.
//   Capacity: DEPTH + 2 words total; in_ready low when full.
//   Invariants: ob_count + inflight <= 2; FIFO order preserved; no SRAM read of unwritten slot.
// TESTING
//   T1 reset: hold rst 2 cycles -> out_valid=0, empty=1, count=0; 1st cycle after: in_ready=1, ren=wen=0.
//   T2 single word: push 0xA5 at t0 -> wen t0 addr 0; ren t1 addr 0; out_valid t3, out_data=0xA5.
//   T3 fill/drain (DEPTH=32): out_ready=0, push 0..40 -> 34 accepted, count=34, full=1, in_ready=0;
//     out_ready=1 -> outputs 0..33 in order, then empty=1.
//   T4 contention: in_valid & out_ready held high -> ren&wen never both high; grants alternate;
//     steady throughput 1 word/2 cycles; data in order.
//   T5 wrap: 200 words, random in_valid/out_ready stalls -> order preserved, addrs wrap 31->0, no loss.
//   T6 mid-op reset: 5 words queued, pulse rst -> empty=1; push 0x77 -> first output 0x77.

Source files
------------

// File: rtl/sram_fifo_ctrl.sv
// Ready/valid FIFO controller backed by an external single-port SRAM with 1-cycle read latency.
// Port arbitration alternates on write/prefetch contention; a 2-entry output buffer hides read latency.
module sram_fifo_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 3),
    localparam int MW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic [AW-1:0]    sram_addr,
    output logic             sram_ren,
    output logic             sram_wen,
    output logic [WIDTH-1:0] sram_d,
    input  logic [WIDTH-1:0] sram_q
);

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [MW-1:0]    mem_count;
    logic             inflight;
    logic [1:0]       ob_count;
    logic [WIDTH-1:0] ob [2];
    logic             prio_wr;

    logic [1:0] ob_occ;
    logic       rd_req, wr_ok, wr_gnt, rd_gnt, contention, pop;

    assign ob_occ     = ob_count + {1'b0, inflight};
    assign rd_req     = (mem_count != '0) && (ob_occ < 2'd2);
    assign wr_ok      = mem_count < MW'(DEPTH);
    // in_ready depends only on state, never on in_valid
    assign in_ready   = !rst && wr_ok && !(rd_req && !prio_wr);
    assign wr_gnt     = in_valid && in_ready;
    assign rd_gnt     = !rst && rd_req && !wr_gnt;
    assign contention = rd_req && in_valid && wr_ok;

    assign sram_wen  = wr_gnt;
    assign sram_ren  = rd_gnt;
    assign sram_addr = wr_gnt ? wr_ptr : rd_ptr;
    assign sram_d    = in_data;

    assign out_valid = ob_count != 2'd0;
    assign out_data  = ob[0];
    assign pop       = out_valid && out_ready;

    assign count = CW'(mem_count) + CW'(ob_count) + CW'(inflight);
    assign full  = mem_count == MW'(DEPTH);
    assign empty = count == '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            inflight  <= 1'b0;
            ob_count  <= 2'd0;
            prio_wr   <= 1'b0;
            ob[0]     <= '0;
            ob[1]     <= '0;
        end else begin
            if (wr_gnt) wr_ptr <= wr_ptr + AW'(1);
            if (rd_gnt) rd_ptr <= rd_ptr + AW'(1);
            if (wr_gnt && !rd_gnt)
                mem_count <= mem_count + MW'(1);
            else if (rd_gnt && !wr_gnt)
                mem_count <= mem_count - MW'(1);
            inflight <= rd_gnt;
            if (contention) prio_wr <= !prio_wr;

            // Pop shifts the head; a same-cycle capture lands in the slot left after the pop.
            if (pop) ob[0] <= ob[1];
            if (inflight) begin
                if ((pop ? ob_count - 2'd1 : ob_count) == 2'd0)
                    ob[0] <= sram_q;
                else
                    ob[1] <= sram_q;
            end
            ob_count <= ob_count + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule
